// File: rtl/fx3_ingress_parser.sv
// fx3_ingress_parser: claims FX3 ingress ping-pong FIFO blocks and splits each into a header and a payload stream.
// Define FX3_PARSER_CHECKSUM_EN to expect and verify a trailing XOR checksum word after the payload.
module fx3_ingress_parser #(
   parameter logic [7:0] MAGIC = 8'hCD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_ppfifo_rdy,
   output logic        o_ppfifo_act,
   input  logic [23:0] i_ppfifo_size,
   output logic        o_ppfifo_stb,
   input  logic [31:0] i_ppfifo_data,
   output logic [7:0]  o_cmd,
   output logic [15:0] o_cmd_len,
   output logic        o_cmd_valid,
   input  logic        i_cmd_ack,
   output logic [31:0] o_data,
   output logic        o_data_valid,
   input  logic        i_data_ready,
   output logic        o_data_last,
   output logic        o_err_magic,
   output logic        o_err_len,
   output logic        o_err_csum,
   output logic [15:0] o_pkt_count
);
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 24;
   localparam int unsigned LW = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_HEADER, S_CMD, S_PAYLOAD,
`ifdef FX3_PARSER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DRAIN, S_RELEASE
   } state_e;

   state_e        state_q;
   logic          act_q, stb_q;
   logic [SW-1:0] remaining_q;
   logic [LW-1:0] pops_left_q;
   logic [7:0]    cmd_q;
   logic [LW-1:0] cmd_len_q;
   logic          cmd_valid_q;
   logic [DW-1:0] out_data_q, skid_data_q;
   logic          out_valid_q, out_last_q, skid_valid_q, skid_last_q;
   logic          err_magic_q, err_len_q;
   logic [LW-1:0] pkt_count_q;
`ifdef FX3_PARSER_CHECKSUM_EN
   logic [DW-1:0] xor_q;
   logic          err_csum_q, len_err_seen_q;
`endif

   logic [SW-1:0] rem_next_d, rem_after_hdr_d, avail_d;
   logic [LW-1:0] hdr_len_d, eff_d, pops_next_d;
   logic [1:0]    occ_next_d;
   logic          in_valid_d, in_last_d, xfer_d, len_err_d, room_d;

   // Word accounting, header clamp and output-stage occupancy
   always_comb begin
      rem_next_d      = remaining_q - SW'(stb_q);
      rem_after_hdr_d = remaining_q - SW'(1);
`ifdef FX3_PARSER_CHECKSUM_EN
      avail_d         = (rem_after_hdr_d == '0) ? '0 : rem_after_hdr_d - SW'(1);
`else
      avail_d         = rem_after_hdr_d;
`endif
      hdr_len_d       = i_ppfifo_data[15:0];
      eff_d           = (avail_d < SW'(hdr_len_d)) ? avail_d[LW-1:0] : hdr_len_d;
      len_err_d       = (eff_d != hdr_len_d);
      in_valid_d      = stb_q && (state_q == S_PAYLOAD);
      in_last_d       = (pops_left_q == LW'(1));
      pops_next_d     = pops_left_q - LW'(in_valid_d);
      xfer_d          = out_valid_q && i_data_ready;
      occ_next_d      = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(in_valid_d) - 2'(xfer_d);
      room_d          = (occ_next_d < 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         act_q        <= 1'b0;
         stb_q        <= 1'b0;
         remaining_q  <= '0;
         pops_left_q  <= '0;
         cmd_q        <= '0;
         cmd_len_q    <= '0;
         cmd_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_last_q  <= 1'b0;
         err_magic_q  <= 1'b0;
         err_len_q    <= 1'b0;
         pkt_count_q  <= '0;
`ifdef FX3_PARSER_CHECKSUM_EN
         xor_q          <= '0;
         err_csum_q     <= 1'b0;
         len_err_seen_q <= 1'b0;
`endif
      end else begin
         err_magic_q <= 1'b0;
         err_len_q   <= 1'b0;
         remaining_q <= rem_next_d;
         pops_left_q <= pops_next_d;
`ifdef FX3_PARSER_CHECKSUM_EN
         err_csum_q  <= 1'b0;
         if (in_valid_d) xor_q <= xor_q ^ i_ppfifo_data;
`endif
         // Output register refills from the skid entry first so order is preserved
         if (!out_valid_q || xfer_d) begin
            if (skid_valid_q) begin
               out_valid_q  <= 1'b1;
               out_data_q   <= skid_data_q;
               out_last_q   <= skid_last_q;
               skid_valid_q <= in_valid_d;
               if (in_valid_d) begin
                  skid_data_q <= i_ppfifo_data;
                  skid_last_q <= in_last_d;
               end
            end else begin
               out_valid_q <= in_valid_d;
               out_last_q  <= in_valid_d && in_last_d;
               if (in_valid_d) out_data_q <= i_ppfifo_data;
            end
         end else if (in_valid_d) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= i_ppfifo_data;
            skid_last_q  <= in_last_d;
         end

         case (state_q)
            S_IDLE: begin
               if (i_ppfifo_rdy) begin
                  act_q   <= 1'b1;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               remaining_q <= i_ppfifo_size;
               if (i_ppfifo_size == '0) begin
                  act_q   <= 1'b0;
                  state_q <= S_RELEASE;
               end else begin
                  stb_q   <= 1'b1;
                  state_q <= S_HEADER;
               end
            end
            S_HEADER: begin
               if (i_ppfifo_data[31:24] != MAGIC) begin
                  err_magic_q <= 1'b1;
                  stb_q       <= (rem_next_d != '0);
                  state_q     <= S_DRAIN;
               end else begin
                  stb_q       <= 1'b0;
                  cmd_q       <= i_ppfifo_data[23:16];
                  cmd_len_q   <= eff_d;
                  cmd_valid_q <= 1'b1;
                  err_len_q   <= len_err_d;
                  pops_left_q <= eff_d;
                  pkt_count_q <= pkt_count_q + LW'(1);
`ifdef FX3_PARSER_CHECKSUM_EN
                  xor_q          <= i_ppfifo_data;
                  len_err_seen_q <= len_err_d;
`endif
                  state_q     <= S_CMD;
               end
            end
            S_CMD: begin
               if (i_cmd_ack) begin
                  cmd_valid_q <= 1'b0;
                  if (cmd_len_q != '0) begin
                     stb_q   <= 1'b1;
                     state_q <= S_PAYLOAD;
                  end else begin
`ifdef FX3_PARSER_CHECKSUM_EN
                     stb_q   <= len_err_seen_q ? (rem_next_d != '0) : 1'b1;
                     state_q <= len_err_seen_q ? S_DRAIN : S_CSUM;
`else
                     stb_q   <= (rem_next_d != '0);
                     state_q <= S_DRAIN;
`endif
                  end
               end
            end
            S_PAYLOAD: begin
               // Pop only when the word is guaranteed a slot even if the consumer stalls
               stb_q <= (pops_next_d != '0) && room_d;
               if (xfer_d && out_last_q) begin
`ifdef FX3_PARSER_CHECKSUM_EN
                  stb_q   <= len_err_seen_q ? (rem_next_d != '0) : 1'b1;
                  state_q <= len_err_seen_q ? S_DRAIN : S_CSUM;
`else
                  stb_q   <= (rem_next_d != '0);
                  state_q <= S_DRAIN;
`endif
               end
            end
`ifdef FX3_PARSER_CHECKSUM_EN
            S_CSUM: begin
               err_csum_q <= (i_ppfifo_data != xor_q);
               stb_q      <= (rem_next_d != '0);
               state_q    <= S_DRAIN;
            end
`endif
            S_DRAIN: begin
               if (rem_next_d == '0) begin
                  stb_q   <= 1'b0;
                  act_q   <= 1'b0;
                  state_q <= S_RELEASE;
               end else begin
                  stb_q <= 1'b1;
               end
            end
            S_RELEASE: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   assign o_ppfifo_act = act_q;
   assign o_ppfifo_stb = stb_q;
   assign o_cmd        = cmd_q;
   assign o_cmd_len    = cmd_len_q;
   assign o_cmd_valid  = cmd_valid_q;
   assign o_data       = out_data_q;
   assign o_data_valid = out_valid_q;
   assign o_data_last  = out_last_q;
   assign o_err_magic  = err_magic_q;
   assign o_err_len    = err_len_q;
   assign o_pkt_count  = pkt_count_q;
`ifdef FX3_PARSER_CHECKSUM_EN
   assign o_err_csum   = err_csum_q;
`else
   assign o_err_csum   = 1'b0;
`endif

endmodule

// File: tb/tb_fx3_ingress_parser.sv
// Bench for fx3_ingress_parser: FIFO block model, header/payload scoreboard and directed packet sequence.
`timescale 1ns/1ps
module tb_fx3_ingress_parser;
`ifdef FX3_PARSER_CHECKSUM_EN
   localparam int CSUM_WORDS = 1;
`else
   localparam int CSUM_WORDS = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_ppfifo_rdy = 1'b0;
   logic        o_ppfifo_act;
   logic [23:0] i_ppfifo_size = 24'd0;
   logic        o_ppfifo_stb;
   logic [31:0] i_ppfifo_data = 32'd0;
   logic [7:0]  o_cmd;
   logic [15:0] o_cmd_len;
   logic        o_cmd_valid;
   logic        i_cmd_ack = 1'b0;
   logic [31:0] o_data;
   logic        o_data_valid;
   logic        i_data_ready = 1'b0;
   logic        o_data_last;
   logic        o_err_magic;
   logic        o_err_len;
   logic        o_err_csum;
   logic [15:0] o_pkt_count;

   int    n_cmp = 0;
   int    n_fail = 0;
   string cur_tag = "reset";

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, tag, obs, exp);
      end
   endtask

   fx3_ingress_parser #(.MAGIC(8'hCD)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act), .i_ppfifo_size(i_ppfifo_size),
      .o_ppfifo_stb(o_ppfifo_stb), .i_ppfifo_data(i_ppfifo_data),
      .o_cmd(o_cmd), .o_cmd_len(o_cmd_len), .o_cmd_valid(o_cmd_valid), .i_cmd_ack(i_cmd_ack),
      .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready), .o_data_last(o_data_last),
      .o_err_magic(o_err_magic), .o_err_len(o_err_len), .o_err_csum(o_err_csum), .o_pkt_count(o_pkt_count)
   );

   always #5 clk = ~clk;

   logic [31:0] blk [$];
   logic [23:0] exp_hdr_q [$];
   logic [32:0] exp_dat_q [$];
   int          rd_idx = 0;
   int          stb_cnt = 0;
   int          ready_mode = 0;
   int          cyc = 0;
   logic        vseen = 1'b0;
   int          em_cnt = 0, el_cnt = 0, ec_cnt = 0;
   int          streak = 0, last_xfer = -10;
   logic        held_v = 1'b0, held_l = 1'b0;
   logic [31:0] held_d = 32'd0;
   logic [23:0] eh;
   logic [32:0] ed;
   logic [15:0] exp_pkt = 16'd0;
   int          exp_mag, exp_len, exp_csum, exp_eff;

   // FIFO read side: a strobe during a cycle advances the read pointer at its closing edge
   always @(posedge clk) begin
      if (o_ppfifo_stb) begin
         stb_cnt++;
         rd_idx++;
      end else if (!o_ppfifo_act) begin
         rd_idx = 0;
      end
   end

   always @(negedge clk)
      i_ppfifo_data = (rd_idx < blk.size()) ? blk[rd_idx] : 32'hDEAD_BEEF;

   // Consumer side: drives ack/ready and checks every header and word against the scoreboard
   always @(negedge clk) begin
      cyc++;
      i_data_ready = (ready_mode == 1) ? cyc[0] : (ready_mode == 0);
      if (!rst_n) begin
         i_cmd_ack = 1'b0;
         vseen     = 1'b0;
         held_v    = 1'b0;
      end else begin
         i_cmd_ack = o_cmd_valid && vseen;
         vseen     = o_cmd_valid;
         if (o_err_magic) em_cnt++;
         if (o_err_len)   el_cnt++;
         if (o_err_csum)  ec_cnt++;
         if (o_cmd_valid && i_cmd_ack) begin
            if (exp_hdr_q.size() == 0) begin
               check("hdr_unexpected", o_cmd_valid, 1'b0);
            end else begin
               eh = exp_hdr_q.pop_front();
               check("cmd", o_cmd, eh[23:16]);
               check("cmd_len", o_cmd_len, eh[15:0]);
            end
         end
         if (held_v) begin
            check("stall_valid", o_data_valid, 1'b1);
            check("stall_data", o_data, held_d);
            check("stall_last", o_data_last, held_l);
         end
         held_v = o_data_valid && !i_data_ready;
         held_d = o_data;
         held_l = o_data_last;
         if (o_data_valid && i_data_ready) begin
            if (exp_dat_q.size() == 0) begin
               check("data_unexpected", o_data_valid, 1'b0);
            end else begin
               ed = exp_dat_q.pop_front();
               check("data", o_data, ed[31:0]);
               check("last", o_data_last, ed[32]);
            end
            streak    = (cyc == last_xfer + 1) ? streak + 1 : 1;
            last_xfer = cyc;
         end
      end
   end

   // Reference model of one block: header, clamped payload, error pulses
   task automatic expect_block();
      int n, avail, len;
      logic [31:0] hdr, x;
      n = blk.size();
      exp_mag = 0; exp_len = 0; exp_csum = 0; exp_eff = 0;
      if (n > 0) begin
         hdr = blk[0];
         if (hdr[31:24] != 8'hCD) exp_mag = 1;
         else begin
            avail = n - 1 - CSUM_WORDS;
            if (avail < 0) avail = 0;
            len     = int'(hdr[15:0]);
            exp_eff = (len < avail) ? len : avail;
            exp_len = (exp_eff != len) ? 1 : 0;
            exp_hdr_q.push_back({hdr[23:16], 16'(exp_eff)});
            x = hdr;
            for (int i = 1; i <= exp_eff; i++) begin
               exp_dat_q.push_back({(i == exp_eff), blk[i]});
               x = x ^ blk[i];
            end
            if (CSUM_WORDS == 1 && exp_len == 0) exp_csum = (blk[exp_eff + 1] != x) ? 1 : 0;
            exp_pkt = exp_pkt + 16'd1;
         end
      end
   endtask

   task automatic run_block(input string tag, input int mode);
      int s0, m0, l0, c0, t;
      cur_tag    = tag;
      ready_mode = mode;
      expect_block();
      s0 = stb_cnt; m0 = em_cnt; l0 = el_cnt; c0 = ec_cnt;
      i_ppfifo_size = 24'(blk.size());
      i_ppfifo_rdy  = 1'b1;
      t = 0;
      while (!o_ppfifo_act && t < 20) begin @(negedge clk); t++; end
      check("act_rise", o_ppfifo_act, 1'b1);
      i_ppfifo_rdy = 1'b0;
      t = 0;
      while (o_ppfifo_act && t < 2000) begin @(negedge clk); t++; end
      check("act_fall", o_ppfifo_act, 1'b0);
      repeat (2) @(negedge clk);
      check("strobes", stb_cnt - s0, blk.size());
      check("err_magic", em_cnt - m0, exp_mag);
      check("err_len", el_cnt - l0, exp_len);
      check("err_csum", ec_cnt - c0, exp_csum);
      check("hdr_pending", exp_hdr_q.size(), 0);
      check("data_pending", exp_dat_q.size(), 0);
      check("pkt_count", o_pkt_count, exp_pkt);
      if (mode == 0 && exp_eff > 0) check("streak", streak, exp_eff);
   endtask

   initial begin
      int t;
      #2 rst_n = 1'b0;
      #1;
      check("reset_outputs", {o_ppfifo_act, o_ppfifo_stb, o_cmd, o_cmd_len, o_cmd_valid, o_data, o_data_valid,
                              o_data_last, o_err_magic, o_err_len, o_err_csum, o_pkt_count}, 80'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      blk = '{32'hCD01_0004, 32'd1, 32'd2, 32'd3, 32'd4};
      run_block("normal", 0);
      blk = '{32'hAB01_0002, 32'h7, 32'h8};
      run_block("bad_magic", 0);
      blk = '{32'hCD02_0010, 32'h5, 32'h6};
      run_block("over_len", 0);
      blk = '{32'hCD04_0005, 32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
      run_block("backpressure", 1);
      blk.delete();
      run_block("zero_size", 0);
      blk = '{32'hCD03_0001, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
      run_block("trailing", 0);
`ifdef FX3_PARSER_CHECKSUM_EN
      blk = '{32'hCD05_0002, 32'hA, 32'hB, 32'hCD05_0002 ^ 32'hA ^ 32'hB};
      run_block("csum_good", 0);
      blk = '{32'hCD05_0002, 32'hA, 32'hB, 32'hCD05_0003 ^ 32'hA ^ 32'hB};
      run_block("csum_bad", 0);
`endif

      // Abandon a block mid-payload with the consumer stalled
      cur_tag    = "reset_mid";
      ready_mode = 2;
      blk = '{32'hCD06_0008, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      expect_block();
      i_ppfifo_size = 24'(blk.size());
      i_ppfifo_rdy  = 1'b1;
      t = 0;
      while (!o_data_valid && t < 50) begin
         @(negedge clk);
         if (o_ppfifo_act) i_ppfifo_rdy = 1'b0;
         t++;
      end
      check("valid_before_reset", o_data_valid, 1'b1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("reset_mid_outputs", {o_ppfifo_act, o_ppfifo_stb, o_cmd, o_cmd_len, o_cmd_valid, o_data, o_data_valid,
                                  o_data_last, o_err_magic, o_err_len, o_err_csum, o_pkt_count}, 80'd0);
      exp_hdr_q.delete();
      exp_dat_q.delete();
      exp_pkt = 16'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ready_mode = 0;
      @(negedge clk);

      blk = '{32'hCD07_0003, 32'h21, 32'h22, 32'h23, 32'h24};
      run_block("after_reset", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fx3_ingress_parser.md
# fx3_ingress_parser

Consumes packets that the FX3 GPIF bus controller has deposited into its ingress ping-pong FIFO, one FIFO block at a time. Each block is validated and split into a command header and a payload word stream with valid/ready backpressure and a last flag. It sits directly downstream of the FX3 bus controller's ingress FIFO read side and upstream of the host-command master.

## Interface
- `MAGIC`, default 8'hCD: required value of header bits [31:24].
- `clk` in 1: system clock, same domain as the ingress FIFO read clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_ppfifo_rdy` in 1: an ingress FIFO block is ready to be activated.
- `o_ppfifo_act` out 1: the block is claimed; held until the block is fully consumed.
- `i_ppfifo_size` in 24: word count of the activated block; valid while `o_ppfifo_act` is high.
- `o_ppfifo_stb` out 1: pops the current word. The next word is presented the following cycle.
- `i_ppfifo_data` in 32: current word; valid from the cycle after `o_ppfifo_act` rises.
- `o_cmd` out 8: command byte, from header [23:16].
- `o_cmd_len` out 16: payload length in words, from header [15:0], after clamping.
- `o_cmd_valid` out 1: header available; held until `i_cmd_ack`.
- `i_cmd_ack` in 1: consumer accepts the header.
- `o_data` out 32: payload word.
- `o_data_valid` out 1: payload word is valid.
- `i_data_ready` in 1: consumer accepts the word; a transfer occurs when valid and ready are both high.
- `o_data_last` out 1: marks the final payload word.
- `o_err_magic` out 1: one-cycle pulse when a header is rejected.
- `o_err_len` out 1: one-cycle pulse when the length is clamped.
- `o_err_csum` out 1: one-cycle pulse on checksum mismatch (checksum build only).
- `o_pkt_count` out 16: count of packets whose header was accepted; wraps at 16'hFFFF to 0.

## Operation
Reset values:
- All outputs are 0.
- State is IDLE.

States and transitions:
- **IDLE:** if `i_ppfifo_rdy`, assert `o_ppfifo_act` and go to WAIT.
- **WAIT:** wait one cycle; latch `i_ppfifo_size` into `remaining` (24 bits).
  - If `remaining` is 0, go to RELEASE.
  - Otherwise go to HEADER.
- **HEADER:** pop word 0 and decrement `remaining`.
  - If [31:24] ≠ MAGIC: pulse `o_err_magic` and go to DRAIN.
  - Otherwise compute the effective length `eff = min(hdr_len, remaining − C)`, where C = 1 with the checksum build and 0 without. Negative results clamp to 0.
  - If `eff` ≠ `hdr_len`, pulse `o_err_len`.
  - Load `o_cmd`, `o_cmd_len = eff`, `o_cmd_valid = 1`. Increment `o_pkt_count`. Go to CMD.
- **CMD:** hold the header outputs until `i_cmd_ack`, then clear `o_cmd_valid`.
  - If `eff` is 0, go to CSUM (checksum build) or DRAIN.
  - Otherwise go to PAYLOAD.
- **PAYLOAD:** stream `eff` words.
  - `o_ppfifo_stb` fires only when the output stage can accept a word. A 1-entry skid register absorbs the pop-to-data cycle.
  - `o_data_last` is high on word `eff`.
  - After the last transfer, go to CSUM or DRAIN.
- **CSUM** (checksum build only): pop one word. It must equal the XOR of the header and all payload words; otherwise pulse `o_err_csum`. Skipped when `o_err_len` fired for this block. Go to DRAIN.
- **DRAIN:** strobe one word per cycle until `remaining` is 0, discarding trailing words. Go to RELEASE.
- **RELEASE:** deassert `o_ppfifo_act` for one cycle, then return to IDLE.

Boundary conditions:
- `rst_n` low at any point: immediate return to reset values. Any partially consumed block is abandoned; the FIFO is reset by the same reset.
- `i_data_ready` held low: the stream stalls indefinitely with no loss and no extra pops.

## Timing
- IDLE with `i_ppfifo_rdy` high to `o_ppfifo_act` high: 1 cycle.
- `o_ppfifo_act` high to the header pop: 2 cycles.
- Header pop to `o_cmd_valid`: 1 cycle.
- `i_cmd_ack` to the first `o_data_valid`: at most 3 cycles.
- Sustained payload throughput with `i_data_ready` held high: 1 word per cycle.
- Stall response: `o_data_valid`, `o_data` and `o_data_last` stay constant while `i_data_ready` is low.
- `o_ppfifo_stb` never fires when `remaining` is 0.
- Error pulses last exactly 1 cycle.

## Configuration
- **`FX3_PARSER_CHECKSUM_EN` defined:** each packet carries a trailing XOR checksum word after the payload. C = 1, the CSUM state is present, and `o_err_csum` is driven.
- **Undefined:** there is no checksum word. C = 0, CSUM is removed from the state machine, and `o_err_csum` is tied to 0.

## Test plan
- **Normal packet:** block of size 5, words CD01_0004, 1, 2, 3, 4; `i_cmd_ack` 1 cycle after valid; ready held high (non-checksum build).
  - Expect `o_cmd` = 01 and `o_cmd_len` = 4.
  - Expect data words 1–4 on consecutive cycles, with `o_data_last` on word 4.
  - Expect `o_pkt_count` = 1.
- **Bad magic:** block of size 3 with header AB01_0002.
  - Expect a single `o_err_magic` pulse and no `o_cmd_valid`.
  - Expect 3 strobes in total, then `o_ppfifo_act` deasserts.
- **Over-length:** size 3 with header CD02_0010.
  - Expect `o_err_len`, `o_cmd_len` = 2, and exactly 2 payload words.
- **Backpressure:** normal packet with `i_data_ready` toggled 1010…
  - Expect all words delivered in order, no duplicates, and the strobe count equal to the block size.
- **Zero and trailing data:** block of size 0 releases with no strobe. Size 6 with header CD03_0001 delivers 1 word, then drains the remaining 4.
- **Checksum build:** size 4 with words CD05_0002, A, B, and the XOR of all three → no error. Corrupting the last word → a single `o_err_csum` pulse. Asserting `rst_n` low mid-payload → all outputs return to 0 immediately.
